gray_sync_dec: RTL and testbench

GRAY_SYNC_DEC -- requirements
Module: gray_sync_dec

---
 rtl/gray_pkg.sv | 31 +++
 rtl/gray_sync_dec_if.sv | 23 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/gray_sync_dec.sv | 67 ++++++
 tb/tb_gray_sync_dec.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - Gray/binary conversion and popcount helpers shared by gray_cnt and gray_sync_dec
package gray_pkg;

  localparam int GRAY_W_MAX = 32;

  typedef logic [GRAY_W_MAX-1:0] gray_word_t;

  // Callers zero-extend narrower words; leading zeros do not disturb the XOR chain.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
    for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [5:0] popcount(input gray_word_t v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < GRAY_W_MAX; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/gray_sync_dec_if.sv
// rtl/gray_sync_dec_if.sv - Pointer input and decoded status bundle for gray_sync_dec
interface gray_sync_dec_if #(
  parameter int N = 4
);
  logic [N-1:0] gray_in;
  logic         err_clr;
  logic [N-1:0] gray_sync;
  logic [N-1:0] bin;
  logic [N-1:0] delta;
  logic         step;
  logic         valid;
  logic         err;

  modport master (
    output gray_in, err_clr,
    input  gray_sync, bin, delta, step, valid, err
  );

  modport slave (
    input  gray_in, err_clr,
    output gray_sync, bin, delta, step, valid, err
  );
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - Plain two-flop synchronizer with a parameterised reset value
module sync_2ff #(
  parameter int           W       = 2,
  parameter logic [W-1:0] rst_val = '0
) (
  input  logic         clk,
  input  logic         rstp,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;

  // Nothing sits between the flops so the first stage has a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (rstp) begin
      s1 <= rst_val;
      q  <= rst_val;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/gray_sync_dec.sv
// rtl/gray_sync_dec.sv - Synchronises a foreign-domain Gray pointer, decodes it and flags illegal jumps
module gray_sync_dec
  import gray_pkg::*;
#(
  parameter int   N         = 4,
  parameter logic first_bit = 1'b0
) (
  input logic           clk,
  input logic           rstp,
  gray_sync_dec_if.slave bus
);
  localparam logic [N-1:0] RST_VAL = {{(N-1){1'b0}}, first_bit};

  logic [N-1:0] s2;
  logic [N-1:0] bin_q;
  logic [N-1:0] delta_q;
  logic         step_q;
  logic         err_q;
  logic [1:0]   cnt_q;
  logic         valid_w;
  logic [N-1:0] bin_next;
  logic [N-1:0] delta_next;
  logic [N-1:0] prev_gray;
  logic         err_set;

  sync_2ff #(.W(N), .rst_val(RST_VAL)) u_sync (
    .clk  (clk),
    .rstp (rstp),
    .d    (bus.gray_in),
    .q    (s2)
  );

  assign valid_w = (cnt_q == 2'd3);

  // bin always holds the decode of last cycle's s2, so re-encoding it recovers the previous pointer.
  always_comb begin
    bin_next   = N'(gray2bin(gray_word_t'(s2)));
    delta_next = bin_next - bin_q;
    prev_gray  = N'(bin2gray(gray_word_t'(bin_q)));
    err_set    = valid_w && (popcount(gray_word_t'(s2 ^ prev_gray)) > 6'd1);
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      bin_q   <= RST_VAL;
      delta_q <= '0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      bin_q   <= bin_next;
      delta_q <= delta_next;
      step_q  <= valid_w && (delta_next == N'(1));
      err_q   <= err_set | (err_q & ~bus.err_clr);
      if (cnt_q != 2'd3) begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  assign bus.gray_sync = s2;
  assign bus.bin       = bin_q;
  assign bus.delta     = delta_q;
  assign bus.step      = step_q;
  assign bus.valid     = valid_w;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_gray_sync_dec.sv
// tb/tb_gray_sync_dec.sv - Self-checking bench for gray_sync_dec (first_bit 0 and 1 instances)
module tb_gray_sync_dec;
  logic       clk = 1'b0;
  logic       rstp;
  logic [3:0] gray_in;
  logic       err_clr;
  int         n_checks = 0;
  int         n_errors = 0;

  gray_sync_dec_if #(.N(4)) if0 ();
  gray_sync_dec_if #(.N(4)) if1 ();

  assign if0.gray_in = gray_in;
  assign if0.err_clr = err_clr;
  assign if1.gray_in = gray_in;
  assign if1.err_clr = err_clr;

  gray_sync_dec #(.N(4), .first_bit(1'b0)) dut0 (.clk(clk), .rstp(rstp), .bus(if0));
  gray_sync_dec #(.N(4), .first_bit(1'b1)) dut1 (.clk(clk), .rstp(rstp), .bus(if1));

  always #5 clk = ~clk;

  // Reference: binary value found by searching for the number whose Gray code matches.
  function automatic logic [3:0] dec(input logic [3:0] g);
    for (int v = 0; v < 16; v++) begin
      if ((4'(v) ^ (4'(v) >> 1)) == g) return 4'(v);
    end
    return 4'd0;
  endfunction

  logic [3:0] m_s1 [2];
  logic [3:0] m_gs [2];
  logic [3:0] m_gsp [2];
  logic [3:0] m_bin [2];
  logic [3:0] m_delta [2];
  logic       m_step [2];
  logic       m_err [2];
  logic       m_valid = 1'b0;
  int         m_t = 0;
  logic [3:0] m_ogs;
  logic [3:0] m_obin;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rstp) begin
        m_s1[d] = 4'(d); m_gs[d] = 4'(d); m_gsp[d] = 4'(d); m_bin[d] = 4'(d);
        m_delta[d] = 4'd0; m_step[d] = 1'b0; m_err[d] = 1'b0;
      end else begin
        m_ogs  = m_gs[d];
        m_obin = m_bin[d];
        m_bin[d]   = dec(m_ogs);
        m_delta[d] = m_bin[d] - m_obin;
        m_step[d]  = m_valid && (m_delta[d] == 4'd1);
        m_err[d]   = (m_valid && ($countones(m_ogs ^ m_gsp[d]) > 1)) || (m_err[d] && !err_clr);
        m_gsp[d]   = m_ogs;
        m_gs[d]    = m_s1[d];
        m_s1[d]    = gray_in;
      end
    end
    if (rstp) m_t = 0;
    else if (m_t < 1000) m_t = m_t + 1;
    m_valid = (m_t >= 3);
  end

  wire [14:0] got0 = {if0.gray_sync, if0.bin, if0.delta, if0.step, if0.valid, if0.err};
  wire [14:0] got1 = {if1.gray_sync, if1.bin, if1.delta, if1.step, if1.valid, if1.err};
  wire [14:0] exp0 = {m_gs[0], m_bin[0], m_delta[0], m_step[0], m_valid, m_err[0]};
  wire [14:0] exp1 = {m_gs[1], m_bin[1], m_delta[1], m_step[1], m_valid, m_err[1]};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstp = 1'b1; gray_in = 4'b0000; err_clr = 1'b0;
    tick(); tick();
    n_checks++;
    if (got0 !== 15'h0) begin
      n_errors++; $display("FAIL reset_dut0 got=%h exp=%h", got0, 15'h0);
    end
    n_checks++;
    if ({if1.gray_sync, if1.bin, if1.valid, if1.err} !== {4'b0001, 4'b0001, 1'b0, 1'b0}) begin
      n_errors++; $display("FAIL reset_dut1 got gs=%b bin=%b valid=%b err=%b exp gs=0001 bin=0001 valid=0 err=0",
                           if1.gray_sync, if1.bin, if1.valid, if1.err);
    end
    rstp = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_checks++;
      if (if0.valid !== (e == 3)) begin
        n_errors++; $display("FAIL valid_edge%0d got=%b exp=%b", e, if0.valid, (e == 3));
      end
    end
  endtask

  task automatic test_sequence();
    logic [3:0] seq [4];
    int pulses;
    seq[0] = 4'b0000; seq[1] = 4'b0001; seq[2] = 4'b0011; seq[3] = 4'b0010;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      gray_in = seq[i];
      tick();
      pulses += int'(if0.step);
      if (i > 0) begin
        n_checks++;
        if (if0.bin !== 4'(i - 1)) begin
          n_errors++; $display("FAIL seq_bin%0d got=%0d exp=%0d", i - 1, if0.bin, i - 1);
        end
      end
      tick();
      pulses += int'(if0.step);
      n_checks++;
      if (if0.gray_sync !== seq[i]) begin
        n_errors++; $display("FAIL seq_gray_sync%0d got=%b exp=%b", i, if0.gray_sync, seq[i]);
      end
    end
    tick();
    pulses += int'(if0.step);
    n_checks++;
    if (if0.bin !== 4'd3) begin
      n_errors++; $display("FAIL seq_bin3 got=%0d exp=3", if0.bin);
    end
    n_checks++;
    if (pulses != 3 || if0.err !== 1'b0) begin
      n_errors++; $display("FAIL seq_steps got pulses=%0d err=%b exp pulses=3 err=0", pulses, if0.err);
    end
  endtask

  task automatic test_wrap();
    gray_in = 4'b1000;
    repeat (4) tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    n_checks++;
    if (if0.bin !== 4'd15 || if0.err !== 1'b0) begin
      n_errors++; $display("FAIL wrap_pre got bin=%0d err=%b exp bin=15 err=0", if0.bin, if0.err);
    end
    gray_in = 4'b0000;
    tick(); tick(); tick();
    n_checks++;
    if ({if0.bin, if0.delta, if0.step, if0.err} !== {4'd0, 4'd1, 1'b1, 1'b0}) begin
      n_errors++; $display("FAIL wrap got bin=%0d delta=%0d step=%b err=%b exp bin=0 delta=1 step=1 err=0",
                           if0.bin, if0.delta, if0.step, if0.err);
    end
  endtask

  task automatic test_illegal_jump();
    gray_in = 4'b0011;
    tick(); tick();
    n_checks++;
    if (if0.gray_sync !== 4'b0011 || if0.err !== 1'b0) begin
      n_errors++; $display("FAIL jump_sync got gs=%b err=%b exp gs=0011 err=0", if0.gray_sync, if0.err);
    end
    tick();
    n_checks++;
    if ({if0.bin, if0.delta, if0.step, if0.err} !== {4'd2, 4'd2, 1'b0, 1'b1}) begin
      n_errors++; $display("FAIL jump got bin=%0d delta=%0d step=%b err=%b exp bin=2 delta=2 step=0 err=1",
                           if0.bin, if0.delta, if0.step, if0.err);
    end
    tick();
    n_checks++;
    if (if0.err !== 1'b1) begin
      n_errors++; $display("FAIL err_sticky got=%b exp=1", if0.err);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_checks++;
    if (if0.err !== 1'b0) begin
      n_errors++; $display("FAIL err_clr got=%b exp=0", if0.err);
    end
  endtask

  task automatic test_set_clr_coincide();
    gray_in = 4'b0000;
    tick(); tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (if0.err !== 1'b1 || if1.err !== 1'b1) begin
      n_errors++; $display("FAIL set_wins got err0=%b err1=%b exp 1 1", if0.err, if1.err);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_checks++;
    if (if0.err !== 1'b0 || if1.err !== 1'b0) begin
      n_errors++; $display("FAIL set_wins_clr got err0=%b err1=%b exp 0 0", if0.err, if1.err);
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] seq [6];
    seq[0] = 4'b0001; seq[1] = 4'b0011; seq[2] = 4'b0010;
    seq[3] = 4'b0110; seq[4] = 4'b0111; seq[5] = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      gray_in = seq[i]; tick(); tick();
    end
    tick();
    n_checks++;
    if (if0.bin !== 4'd6) begin
      n_errors++; $display("FAIL mid_pre got bin=%0d exp=6", if0.bin);
    end
    rstp = 1'b1; tick();
    n_checks++;
    if ({if0.gray_sync, if0.bin, if0.valid, if0.err, if1.bin} !== {4'd0, 4'd0, 1'b0, 1'b0, 4'd1}) begin
      n_errors++; $display("FAIL mid_reset got gs=%b bin=%0d valid=%b err=%b bin1=%0d exp 0000 0 0 0 1",
                           if0.gray_sync, if0.bin, if0.valid, if0.err, if1.bin);
    end
    rstp = 1'b0; gray_in = 4'b0111;
    tick(); tick();
    n_checks++;
    if ({if0.gray_sync, if0.bin, if0.valid} !== {4'b0111, 4'd0, 1'b0}) begin
      n_errors++; $display("FAIL mid_resume_sync got gs=%b bin=%0d valid=%b exp 0111 0 0",
                           if0.gray_sync, if0.bin, if0.valid);
    end
    tick();
    n_checks++;
    if ({if0.bin, if0.valid} !== {4'd5, 1'b1}) begin
      n_errors++; $display("FAIL mid_resume_bin got bin=%0d valid=%b exp 5 1", if0.bin, if0.valid);
    end
  endtask

  task automatic test_random();
    logic [3:0] cur_b;
    int r;
    cur_b = dec(gray_in);
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 9);
      if (r >= 4 && r < 8) cur_b = ($urandom_range(0, 1) == 1) ? cur_b + 4'd1 : cur_b - 4'd1;
      else if (r >= 8) cur_b = 4'($urandom);
      gray_in = cur_b ^ (cur_b >> 1);
      err_clr = ($urandom_range(0, 7) == 0);
      rstp = ($urandom_range(0, 99) == 0);
      tick();
      n_checks++;
      if (got0 !== exp0) begin
        n_errors++; $display("FAIL rand_dut0 cycle=%0d got=%h exp=%h", c, got0, exp0);
      end
      n_checks++;
      if (got1 !== exp1) begin
        n_errors++; $display("FAIL rand_dut1 cycle=%0d got=%h exp=%h", c, got1, exp1);
      end
    end
    rstp = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    rstp = 1'b1; gray_in = 4'b0000; err_clr = 1'b0;
    test_reset();
    test_sequence();
    test_wrap();
    test_illegal_jump();
    test_set_clr_coincide();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
